// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: drives the data bus with a wait-state handshake, formats sub-word loads and stores,
// flags misaligned accesses and bus timeouts, and feeds the MEM/WB register under stall/flush control.
module mem_stage_ws #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     bus_rd_data,
    input  logic                  bus_rdy_,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic                  bus_as_,
    output logic                  bus_rw,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wr_data,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_en,
    input  logic [3:0]            ex_mem_op,
    input  logic [DATA_W-1:0]     ex_mem_wr_data,
    input  logic [REG_ADDR_W-1:0] ex_dst_addr,
    input  logic                  ex_gpr_we_,
    input  logic [DATA_W-1:0]     ex_out,
    output logic                  mem_busy,
    output logic                  mem_en,
    output logic [REG_ADDR_W-1:0] mem_dst_addr,
    output logic                  mem_gpr_we_,
    output logic [DATA_W-1:0]     mem_out,
    output logic [1:0]            mem_exp
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFS_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    localparam logic [1:0] EXP_NONE = 2'b00;
    localparam logic [1:0] EXP_MIS  = 2'b01;
    localparam logic [1:0] EXP_TMO  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  buf_out;
    logic [1:0]         buf_exp;

    logic               is_load;
    logic               is_store;
    logic               size_w;
    logic               size_h;
    logic               sign_ext;
    logic               aligned;
    logic               misalign;
    logic               acc_valid;
    logic [OFS_W-1:0]   ofs;
    logic               req_idle;
    logic               timing_out;
    logic               drive_req;
    logic [DATA_W-1:0]  load_val;
    logic [DATA_W-1:0]  res_out;
    logic [1:0]         res_exp;

    function automatic logic [DATA_W-1:0] load_align(input logic [DATA_W-1:0] raw,
                                                     input logic [OFS_W-1:0]  lane,
                                                     input logic              w,
                                                     input logic              h,
                                                     input logic              sgn);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh = raw >> {lane, 3'b000};
        if (w) begin
            res = sh;
        end else if (h) begin
            res = sgn ? {{(DATA_W-16){sh[15]}}, sh[15:0]} : {{(DATA_W-16){1'b0}}, sh[15:0]};
        end else begin
            res = sgn ? {{(DATA_W-8){sh[7]}}, sh[7:0]} : {{(DATA_W-8){1'b0}}, sh[7:0]};
        end
        return res;
    endfunction

    function automatic logic [BE_W-1:0] store_be(input logic [OFS_W-1:0] lane,
                                                 input logic w,
                                                 input logic h);
        logic [BE_W-1:0] be;
        if (w) begin
            be = {BE_W{1'b1}};
        end else if (h) begin
            be = BE_W'(2'b11) << lane;
        end else begin
            be = BE_W'(1'b1) << lane;
        end
        return be;
    endfunction

    function automatic logic [DATA_W-1:0] store_data(input logic [DATA_W-1:0] d,
                                                     input logic w,
                                                     input logic h);
        logic [DATA_W-1:0] res;
        if (w) begin
            res = d;
        end else if (h) begin
            res = {(DATA_W/16){d[15:0]}};
        end else begin
            res = {BE_W{d[7:0]}};
        end
        return res;
    endfunction

    // Opcode decode and alignment check
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size_w   = 1'b0;
        size_h   = 1'b0;
        sign_ext = 1'b0;
        case (ex_mem_op)
            OP_LW:   begin is_load = 1'b1; size_w = 1'b1; end
            OP_LH:   begin is_load = 1'b1; size_h = 1'b1; sign_ext = 1'b1; end
            OP_LHU:  begin is_load = 1'b1; size_h = 1'b1; end
            OP_LB:   begin is_load = 1'b1; sign_ext = 1'b1; end
            OP_LBU:  begin is_load = 1'b1; end
            OP_SW:   begin is_store = 1'b1; size_w = 1'b1; end
            OP_SH:   begin is_store = 1'b1; size_h = 1'b1; end
            OP_SB:   begin is_store = 1'b1; end
            default: begin is_load = 1'b0; is_store = 1'b0; end
        endcase
        ofs = ex_out[OFS_W-1:0];
        if (size_w) begin
            aligned = (ofs == {OFS_W{1'b0}});
        end else if (size_h) begin
            aligned = ~ofs[0];
        end else begin
            aligned = 1'b1;
        end
        acc_valid = ex_en & (is_load | is_store) & aligned;
        misalign  = ex_en & (is_load | is_store) & ~aligned;
    end

    // Request qualification; the strobe falls in the cycle the wait budget runs out
    always_comb begin
        req_idle   = ~reset & (state == ST_IDLE) & acc_valid & ~stall & ~flush;
        timing_out = (state == ST_WAIT) & (cnt == CNT_LAST) & bus_rdy_ & ~flush;
        drive_req  = ~reset & (req_idle | ((state == ST_WAIT) & ~flush & ~timing_out));
        mem_busy   = (req_idle & bus_rdy_) | ((state == ST_WAIT) & ~flush & bus_rdy_ & ~timing_out);
        load_val   = load_align(bus_rd_data, ofs, size_w, size_h, sign_ext);
    end

    // Bus signalling
    always_comb begin
        bus_addr = ex_out[ADDR_W+OFS_W-1:OFS_W];
        if (drive_req) begin
            bus_as_     = 1'b0;
            bus_rw      = ~is_store;
            bus_be      = is_store ? store_be(ofs, size_w, size_h) : {BE_W{1'b1}};
            bus_wr_data = is_store ? store_data(ex_mem_wr_data, size_w, size_h) : {DATA_W{1'b0}};
        end else begin
            bus_as_     = 1'b1;
            bus_rw      = 1'b1;
            bus_be      = {BE_W{1'b0}};
            bus_wr_data = {DATA_W{1'b0}};
        end
    end

    // Result offered to MEM/WB this cycle
    always_comb begin
        res_out = ex_out;
        res_exp = EXP_NONE;
        case (state)
            ST_IDLE: begin
                if (misalign) begin
                    res_exp = EXP_MIS;
                end else if (req_idle && is_load) begin
                    res_out = load_val;
                end else begin
                    res_out = ex_out;
                end
            end
            ST_WAIT: begin
                if (timing_out) begin
                    res_exp = EXP_TMO;
                end else if (is_load) begin
                    res_out = load_val;
                end else begin
                    res_out = ex_out;
                end
            end
            ST_DONE: begin
                res_out = buf_out;
                res_exp = buf_exp;
            end
            default: begin
                res_out = ex_out;
                res_exp = EXP_NONE;
            end
        endcase
    end

    // Handshake FSM, wait counter and stall buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= {CNT_W{1'b0}};
            buf_out <= {DATA_W{1'b0}};
            buf_exp <= EXP_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= {CNT_W{1'b0}};
                    if (req_idle && bus_rdy_) begin
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        cnt   <= {CNT_W{1'b0}};
                    end else if (!bus_rdy_ || timing_out) begin
                        cnt <= {CNT_W{1'b0}};
                        if (stall) begin
                            state   <= ST_DONE;
                            buf_out <= res_out;
                            buf_exp <= res_exp;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (flush || !stall) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // MEM/WB register: stall holds, flush clears, a pending access inserts a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en       <= 1'b0;
            mem_dst_addr <= {REG_ADDR_W{1'b0}};
            mem_gpr_we_  <= 1'b1;
            mem_out      <= {DATA_W{1'b0}};
            mem_exp      <= EXP_NONE;
        end else if (stall) begin
            mem_en       <= mem_en;
            mem_dst_addr <= mem_dst_addr;
            mem_gpr_we_  <= mem_gpr_we_;
            mem_out      <= mem_out;
            mem_exp      <= mem_exp;
        end else if (flush) begin
            mem_en      <= 1'b0;
            mem_gpr_we_ <= 1'b1;
            mem_out     <= {DATA_W{1'b0}};
            mem_exp     <= EXP_NONE;
        end else if (mem_busy) begin
            mem_en      <= 1'b0;
            mem_gpr_we_ <= 1'b1;
        end else begin
            mem_en       <= ex_en;
            mem_dst_addr <= ex_dst_addr;
            mem_gpr_we_  <= ex_gpr_we_ | (res_exp != EXP_NONE);
            mem_out      <= res_out;
            mem_exp      <= res_exp;
        end
    end

endmodule
